ex_muldiv_unit: RTL and testbench

- Iterative RV M-extension multiply/divide engine in the execute stage.
- Consumes ID/EX register outputs: forwarded operands, funct3 and rd.
- Holds the pipeline via o_busy for multi-cycle operations.
- Presents one result plus a done pulse that the EX/MEM register captures.

---
 rtl/ex_muldiv_unit_pkg.sv | 37 +++
 rtl/ex_muldiv_unit_sign_fix.sv | 12 +
 rtl/ex_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants and helpers for the iterative RV M-extension multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam int unsigned XLEN_32B = 1;
  localparam int unsigned XLEN_64B = 2;

  typedef enum logic [2:0] {
    MD_F3_MUL    = 3'd0,
    MD_F3_MULH   = 3'd1,
    MD_F3_MULHSU = 3'd2,
    MD_F3_MULHU  = 3'd3,
    MD_F3_DIV    = 3'd4,
    MD_F3_DIVU   = 3'd5,
    MD_F3_REM    = 3'd6,
    MD_F3_REMU   = 3'd7
  } md_f3_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic int unsigned md_width(input int unsigned xlen);
    return 32'd1 << (xlen + 32'd4);
  endfunction

  function automatic logic md_a_signed(input md_f3_e f3);
    return f3 inside {MD_F3_MULH, MD_F3_MULHSU, MD_F3_DIV, MD_F3_REM};
  endfunction

  function automatic logic md_b_signed(input md_f3_e f3);
    return f3 inside {MD_F3_MULH, MD_F3_DIV, MD_F3_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Conditional two's-complement negate of an N-bit value.
module md_sign_fix #(
  parameter int unsigned N = 32
) (
  input  logic         i_neg,
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide engine for the EX stage.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_32B,
  localparam int unsigned W   = md_width(XLEN),
  localparam int unsigned CW  = $clog2(W) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clk_en,
  input  logic         i_flush,
  input  logic         i_start,
  input  logic [2:0]   i_f3,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  input  logic [4:0]   i_rd,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic [4:0]   o_rd
);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_f3_e        f3_q, f3_d;
  logic [4:0]    rd_q, rd_d, ord_q, ord_d;
  logic [W-1:0]  opnd_q, opnd_d, res_q, res_d;
  logic          neg_q, neg_d;
  logic [2*W-1:0] acc_q, acc_d;

  md_f3_e        f3_in;
  logic          a_neg, b_neg, ovf;
  logic [W-1:0]  abs_a, abs_b;
  logic [W:0]    mul_sum, div_shift, div_diff;
  logic [2*W-1:0] mul_next, div_next, prod_fix;
  logic [W-1:0]  quo_fix, rem_fix;

  assign f3_in = md_f3_e'(i_f3);
  assign a_neg = md_a_signed(f3_in) & i_op_a[W-1];
  assign b_neg = md_b_signed(f3_in) & i_op_b[W-1];
  assign abs_a = a_neg ? ('0 - i_op_a) : i_op_a;
  assign abs_b = b_neg ? ('0 - i_op_b) : i_op_b;
  assign ovf   = (f3_in inside {MD_F3_DIV, MD_F3_REM}) &&
                 (i_op_a == {1'b1, {(W-1){1'b0}}}) && (i_op_b == '1);

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[W-1:1]};
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = {(div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0]),
                      acc_q[W-2:0], ~div_diff[W]};

  md_sign_fix #(.N(2*W)) u_fix_prod (.i_neg(neg_q), .i_val(mul_next),           .o_val(prod_fix));
  md_sign_fix #(.N(W))   u_fix_quo  (.i_neg(neg_q), .i_val(div_next[W-1:0]),    .o_val(quo_fix));
  md_sign_fix #(.N(W))   u_fix_rem  (.i_neg(neg_q), .i_val(div_next[2*W-1:W]),  .o_val(rem_fix));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ord_d   = ord_q;
    unique case (state_q)
      MD_IDLE: begin
        if (i_start) begin
          f3_d  = f3_in;
          rd_d  = i_rd;
          cnt_d = '0;
          // REM keeps the dividend's sign; unsigned ops never set a_neg/b_neg
          neg_d = (f3_in inside {MD_F3_REM, MD_F3_REMU}) ? a_neg : (a_neg ^ b_neg);
          if (!i_f3[2]) begin
            state_d = MD_MUL;
            opnd_d  = abs_a;
            acc_d   = {{W{1'b0}}, abs_b};
          end else if (i_op_b == '0) begin
            state_d = MD_DONE;
            res_d   = i_f3[1] ? i_op_a : '1;
            ord_d   = i_rd;
          end else if (ovf) begin
            state_d = MD_DONE;
            res_d   = i_f3[1] ? '0 : i_op_a;
            ord_d   = i_rd;
          end else begin
            state_d = MD_DIV;
            opnd_d  = abs_b;
            acc_d   = {{W{1'b0}}, abs_a};
          end
        end
      end
      MD_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = MD_DONE;
          cnt_d   = '0;
          res_d   = (f3_q == MD_F3_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
          ord_d   = rd_q;
        end
      end
      MD_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = MD_DONE;
          cnt_d   = '0;
          res_d   = f3_q[1] ? rem_fix : quo_fix;
          ord_d   = rd_q;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      f3_q    <= MD_F3_MUL;
      rd_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      ord_q   <= '0;
    end else if (i_flush) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ord_q   <= ord_d;
    end
  end

  assign o_busy   = (state_q == MD_IDLE && i_start && !i_flush) ||
                    state_q == MD_MUL || state_q == MD_DIV;
  assign o_done   = (state_q == MD_DONE);
  assign o_result = res_q;
  assign o_rd     = ord_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with hand-computed expected results (W=32).
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, start;
  logic [2:0]  f3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.XLEN(XLEN_32B)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
    .i_start(start), .i_f3(f3), .i_op_a(op_a), .i_op_b(op_b), .i_rd(rd),
    .o_busy(busy), .o_done(done), .o_result(result), .o_rd(rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one op at the next negedge (cycle 0), optionally freeze 5 cycles from freeze_at.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                        input int exp_cyc, input int freeze_at);
    int cyc = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; f3 = f; op_a = a; op_b = b; rd = r;
    #1;
    check({tag, "_busy_c0"}, 32'(busy), 32'd1);
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == freeze_at) clk_en = 1'b0;
      if (cyc == freeze_at + 5) clk_en = 1'b1;
      #1;
      if (done) break;
      if (busy) busy_cnt++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc - 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, 32'(rd_o), 32'(r));
    @(negedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
    f3 = '0; op_a = '0; op_b = '0; rd = '0;
    @(negedge clk); #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", 32'(rd_o), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // multiply
    run_op("mul",    3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, -1);
    run_op("mulhu",  3'd3, 32'd7, 32'hFFFFFFFD, 5'd2, 32'h00000006, 33, -1);
    // divide
    run_op("div",    3'd4, 32'hFFFFFFEC, 32'd3, 5'd3, 32'hFFFFFFFA, 33, -1);
    run_op("rem",    3'd6, 32'hFFFFFFEC, 32'd3, 5'd4, 32'hFFFFFFFE, 33, -1);
    run_op("divu",   3'd5, 32'd100, 32'd7, 5'd5, 32'd14, 33, -1);
    run_op("remu",   3'd7, 32'd100, 32'd7, 5'd6, 32'd2, 33, -1);
    // special cases
    run_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd7, 32'hFFFFFFFF, 1, -1);
    run_op("rem_z",  3'd6, 32'd5, 32'd0, 5'd8, 32'd5, 1, -1);
    run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 1, -1);
    run_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'd0, 1, -1);

    // flush at cycle 10 of a MULH
    seen = 0;
    @(negedge clk);
    start = 1'b1; f3 = 3'd1; op_a = 32'd12; op_b = 32'd34; rd = 5'd11;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) seen++;
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    check("flush_busy_c11", 32'(busy), 32'd0);
    check("flush_done_c11", 32'(done), 32'd0);
    check("flush_no_done", 32'(seen), 32'd0);
    run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 33, -1);

    // start and flush in the same cycle
    seen = 0;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; f3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd = 5'd13;
    #1;
    check("sf_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); start = 1'b0; flush = 1'b0; #1;
      if (done || busy) seen++;
    end
    check("sf_no_activity", 32'(seen), 32'd0);
    check("sf_result_kept", result, 32'd14);

    // clock-enable stall mid-DIV delays completion by 5 cycles
    run_op("div_stall", 3'd4, 32'hFFFFFFEC, 32'd3, 5'd14, 32'hFFFFFFFA, 38, 10);

    // reset mid-MUL
    @(negedge clk);
    start = 1'b1; f3 = 3'd0; op_a = 32'd7; op_b = 32'd3; rd = 5'd15;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); start = 1'b0;
    end
    rst_n = 1'b0; #1;
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_rd", 32'(rd_o), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) seen++;
    end
    check("rst_mid_no_done", 32'(seen), 32'd0);

    // signed high-half products
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFFFFFF, 33, -1);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd17, 32'h40000000, 33, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
